pixel_clip_fifo: RTL
====================

// Module: pixel_clip_fifo
// PURPOSE
//  Buffering/clipping stage between a drawing engine (fillscreen, reuleaux, circle) and vga_adapter.
//  Takes signed pixel requests under a valid/ready handshake and discards off-screen pixels.
//  Queues the rest in a FIFO and replays them as one-cycle vga_plot pulses, pausing while out_stall=1.
//  Raises done only when the engine has signalled its last pixel and every queued pixel has been plotted,
//  so the top-level sequencer can chain the next engine's start.
// PARAMETERS
//  WIDTH   160  screen width; valid x range is 0..WIDTH-1
//  HEIGHT  120  screen height; valid y range is 0..HEIGHT-1
//  DEPTH   16   FIFO entries; power of two, >= 2
//  CW      16   clip_count width
// PORTS
//  clk         in   1         clock (CLOCK_50 domain)
//  rst_n       in   1         asynchronous, active-low reset
//  start       in   1         level; 1 = run job, 0 = idle/abort
//  in_valid    in   1         pixel request valid
//  in_ready    out  1         stage can accept a request this cycle
//  in_x        in   9 signed  requested x
//  in_y        in   8 signed  requested y
//  in_colour   in   3         requested colour
//  in_last     in   1         qualifies the final request of the job
//  out_stall   in   1         1 = do not emit a pixel this cycle
//  vga_x       out  8         to adapter x
//  vga_y       out  7         to adapter y
//  vga_colour  out  3         to adapter colour
//  vga_plot    out  1         one-cycle plot strobe
//  done        out  1         job complete; held until start=0
//  clip_count  out  CW        requests discarded in the current job, saturating
//  fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - All outputs 0, FSM=IDLE, FIFO empty, clip_count=0.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//  - IDLE: in_ready=0. On start=1, go to RUN and clear clip_count.
//  - RUN: in_ready = (fifo_level != DEPTH).
//    An accept happens at an edge where in_valid & in_ready.
//    If that accept carries in_last, go to DRAIN.
//  - DRAIN: in_ready=0. When the FIFO is empty and no pop is pending, go to DONE.
//  - DONE: done=1. On start=0, go to IDLE; done falls on that edge.
//  - start=0 in RUN or DRAIN is an abort: next edge empties the FIFO, forces vga_plot=0, goes to IDLE, done stays 0.
//  Clipping (on accept)
//  - A request is off-screen if in_x<0, in_x>=WIDTH, in_y<0 or in_y>=HEIGHT, using signed compares.
//  - Off-screen requests are dropped and clip_count increments, saturating at 2^CW-1.
//  - On-screen requests are pushed as {in_x[7:0], in_y[6:0], in_colour}.
//  - in_last on a clipped request still moves RUN to DRAIN.
//  Output
//  - Pop at an edge where FSM is RUN or DRAIN, FIFO is not empty and out_stall=0.
//  - On a pop edge, vga_x/vga_y/vga_colour load the FIFO head and vga_plot=1.
//  - On all other edges vga_plot=0; vga_x/vga_y/vga_colour hold their last value.
//  - At most one pixel is emitted per cycle. Emission order equals accept order.
//  - Latency: a request accepted into an empty FIFO at edge t has vga_plot=1 in the cycle after edge t+1.
//    The FIFO has no bypass path.
//  Boundaries
//  - Simultaneous push and pop: fifo_level unchanged; a full FIFO still deasserts in_ready for that cycle.
//  - in_ready depends only on registered state (FSM, fifo_level), never on in_valid.
//  - Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
//  - out_stall held high with a full FIFO: in_ready=0 indefinitely; no request is lost.
//  - in_valid in IDLE, DRAIN or DONE is ignored and not counted.
// TESTING
//  1. start=1, push (5,7,c=2),(159,119,c=1) with in_last on the 2nd -> vga_plot pulses in 2 consecutive cycles;
//     first strobe 2 edges after the first accept; done=1 one cycle later; clip_count=0.
//  2. Push (-1,0),(160,5),(3,120),(0,-4),(10,10),(159,0) -> only (10,10) and (159,0) plotted; clip_count=4.
//  3. out_stall=1, push 16 valid pixels (DEPTH=16) -> fifo_level=16, in_ready=0;
//     release stall -> 16 strobes in order, no gaps, no loss.
//  4. Last request (200,50) carries in_last -> it is not plotted; done asserts once the FIFO empties; clip_count=1.
//  5. 8 pixels queued under stall, drop start -> next edge fifo_level=0, FSM=IDLE, no further vga_plot, done=0.
//  6. rst_n=0 asynchronously mid-drain (between edges) -> outputs 0 immediately; after release, done=0 and in_ready=0 until start.

Source files
------------

// File: rtl/pixel_clip_fifo_if.sv
// Pixel request bus from a drawing engine plus the plot bus towards vga_adapter.
// A request transfers on a rising edge where in_valid && in_ready; in_ready never looks at in_valid.
interface pixel_clip_fifo_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [8:0] in_x;
    logic signed [7:0] in_y;
    logic [2:0]        in_colour;
    logic              in_last;
    logic              out_stall;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;

    modport master (
        output in_valid, in_x, in_y, in_colour, in_last, out_stall,
        input  in_ready, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, in_last, out_stall,
        output in_ready, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/pixel_clip_fifo.sv
// Clips signed pixel requests to the screen, queues on-screen ones and replays them as plot strobes.
// done rises once the last request is accepted and the queue has fully drained.
module pixel_clip_fifo #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 16,
    parameter int CW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    pixel_clip_fifo_if.slave         pix,
    output logic                     done,
    output logic [CW-1:0]            clip_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [1:0]               state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [17:0]         mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [7:0]          vga_x_q;
    logic [6:0]          vga_y_q;
    logic [2:0]          vga_colour_q;
    logic                vga_plot_q;
    logic signed [31:0]  x_ext;
    logic signed [31:0]  y_ext;
    logic                on_screen;
    logic                active;
    logic                abort;
    logic                ready;
    logic                accept;
    logic                push;
    logic                pop;

    assign x_ext     = {{23{pix.in_x[8]}}, pix.in_x};
    assign y_ext     = {{24{pix.in_y[7]}}, pix.in_y};
    assign on_screen = (x_ext >= 0) && (x_ext < WIDTH) && (y_ext >= 0) && (y_ext < HEIGHT);

    assign active = (state == S_RUN) || (state == S_DRAIN);
    assign abort  = active && !start;
    assign ready  = (state == S_RUN) && (level != LW'(DEPTH));
    // An abort edge flushes everything, so nothing is accepted or popped on it.
    assign accept = pix.in_valid && ready && !abort;
    assign push   = accept && on_screen;
    assign pop    = active && !abort && (level != '0) && !pix.out_stall;

    assign pix.in_ready   = ready;
    assign pix.vga_x      = vga_x_q;
    assign pix.vga_y      = vga_y_q;
    assign pix.vga_colour = vga_colour_q;
    assign pix.vga_plot   = vga_plot_q;
    assign fifo_level     = level;
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pix.in_x[7:0], pix.in_y[6:0], pix.in_colour};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            done         <= 1'b0;
            clip_count   <= '0;
        end else if (abort) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            vga_plot_q <= 1'b0;
            done       <= 1'b0;
        end else begin
            vga_plot_q <= pop;
            if (pop) begin
                vga_x_q      <= mem[rd_ptr][17:10];
                vga_y_q      <= mem[rd_ptr][9:3];
                vga_colour_q <= mem[rd_ptr][2:0];
                rd_ptr       <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (accept && !on_screen && (clip_count != '1)) begin
                clip_count <= clip_count + CW'(1);
            end

            // Placed after the counter update so the job-start clear wins.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        clip_count <= '0;
                    end
                end
                S_RUN: begin
                    if (accept && pix.in_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (level == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
